// File: rtl/sram_data_controller.sv
// Bridges 32-bit MEM-stage loads/stores to a 64-bit wait-stated SRAM; stores are read-modify-write.
// Define SRAM_READ_BUFFER_EN to add a single-line read buffer that short-circuits repeat loads.
module sram_data_controller #(
  parameter int unsigned ADDR_BASE        = 1024,
  parameter int unsigned SRAM_WAIT_CYCLES = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        SRAM_WE_N,
  output logic [16:0] SRAM_ADDR,
  inout  logic [63:0] SRAM_DQ
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_RMW_READ,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(SRAM_WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [16:0] addr_q, addr_d;
  logic        half_q, half_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [63:0] merge_q, merge_d;

  logic [31:0] offset;
  logic [63:0] dq_in;
  logic [63:0] merged;
  logic        cnt_done;
  logic        unused_offset_bits;

  assign offset             = address - 32'(ADDR_BASE);
  assign dq_in              = SRAM_DQ;
  assign cnt_done           = (cnt_q == LAST_CNT);
  assign merged             = half_q ? {wdata_q, dq_in[31:0]} : {dq_in[63:32], wdata_q};
  assign unused_offset_bits = ^{offset[31:20], offset[1:0]};

`ifdef SRAM_READ_BUFFER_EN
  logic        buf_valid_q, buf_valid_d;
  logic [16:0] buf_tag_q, buf_tag_d;
  logic [63:0] buf_data_q, buf_data_d;
  logic        buf_hit;

  assign buf_hit = buf_valid_q && (buf_tag_q == offset[19:3]);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 4'd1;
    addr_d  = addr_q;
    half_d  = half_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    merge_d = merge_q;
    ready   = 1'b0;
`ifdef SRAM_READ_BUFFER_EN
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_data_d  = buf_data_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        ready = ~(rd_en | wr_en);
        cnt_d = '0;
        if (wr_en || rd_en) begin
          addr_d  = offset[19:3];
          half_d  = offset[2];
          wdata_d = write_data;
        end
        if (wr_en) begin
          state_d = S_RMW_READ;
        end else if (rd_en) begin
`ifdef SRAM_READ_BUFFER_EN
          if (buf_hit) begin
            rdata_d = offset[2] ? buf_data_q[63:32] : buf_data_q[31:0];
            state_d = S_DONE;
          end else begin
            state_d = S_READ;
          end
`else
          state_d = S_READ;
`endif
        end
      end
      S_READ: begin
        if (cnt_done) begin
          rdata_d = half_q ? dq_in[63:32] : dq_in[31:0];
          state_d = S_DONE;
          cnt_d   = '0;
`ifdef SRAM_READ_BUFFER_EN
          buf_valid_d = 1'b1;
          buf_tag_d   = addr_q;
          buf_data_d  = dq_in;
`endif
        end
      end
      S_RMW_READ: begin
        if (cnt_done) begin
          merge_d = merged;
          state_d = S_WRITE;
          cnt_d   = '0;
`ifdef SRAM_READ_BUFFER_EN
          // Keep the buffered copy coherent with the line about to be written back.
          if (buf_valid_q && (buf_tag_q == addr_q)) begin
            buf_data_d = merged;
          end
`endif
        end
      end
      S_WRITE: begin
        if (cnt_done) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end
      end
      S_DONE: begin
        ready   = 1'b1;
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      half_q  <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      merge_q <= '0;
`ifdef SRAM_READ_BUFFER_EN
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      half_q  <= half_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      merge_q <= merge_d;
`ifdef SRAM_READ_BUFFER_EN
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
`endif
    end
  end

  // Write strobe and bus drive decode straight from state so a reset edge releases them at once.
  assign SRAM_WE_N = (state_q != S_WRITE);
  assign SRAM_DQ   = (state_q == S_WRITE) ? merge_q : 'z;
  assign SRAM_ADDR = addr_q;
  assign read_data = rdata_q;

endmodule

// File: tb/tb_sram_data_controller.sv
// Self-checking bench: word-level reference memory, optional read-buffer model, randomized load/store traffic.
module tb_sram_data_controller;
  localparam int unsigned W    = 5;
  localparam int unsigned BASE = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic        SRAM_WE_N;
  logic [16:0] SRAM_ADDR;
  wire  [63:0] SRAM_DQ;

  sram_data_controller #(.ADDR_BASE(BASE), .SRAM_WAIT_CYCLES(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_en     (rd_en),
    .wr_en     (wr_en),
    .address   (address),
    .write_data(write_data),
    .read_data (read_data),
    .ready     (ready),
    .SRAM_WE_N (SRAM_WE_N),
    .SRAM_ADDR (SRAM_ADDR),
    .SRAM_DQ   (SRAM_DQ)
  );

  always #5 clk = ~clk;

  // External SRAM: 256 lines, drives the bus whenever it is not being written.
  logic [63:0] mem [256];
  logic        pre_we  = 1'b0;
  logic [7:0]  pre_idx = '0;
  logic [63:0] pre_val = '0;

  assign SRAM_DQ = SRAM_WE_N ? mem[SRAM_ADDR[7:0]] : 'z;

  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_val;
    else if (!SRAM_WE_N) mem[SRAM_ADDR[7:0]] <= SRAM_DQ;
  end

  int          we_cnt  = 0;
  logic [63:0] dq_seen = '0;
  always @(negedge clk) begin
    if (!SRAM_WE_N) begin
      we_cnt  <= we_cnt + 1;
      dq_seen <= SRAM_DQ;
    end
  end

  // Reference: flat array of 32-bit words plus the buffered line tag.
  logic [31:0] ref_w [512];
  logic [31:0] exp_rd;
  bit          buf_valid;
  logic [16:0] buf_tag;
  bit          in_done;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [63:0] ref_line(input int unsigned l);
    return {ref_w[2*(l%256)+1], ref_w[2*(l%256)]};
  endfunction

  task automatic measure(output int low);
    low = 0;
    #1;
    while (!ready && low < 200) begin
      low++;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic idle_cycle();
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    address    = $urandom;
    write_data = $urandom;
    @(negedge clk);
    in_done = 1'b0;
  endtask

  task automatic do_op(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input bit from_done);
    logic [31:0] off;
    logic [16:0] line;
    int unsigned widx;
    bit          hit;
    int          exp_low, low, we0;
    off  = a - BASE;
    line = off[19:3];
    widx = (off >> 2) % 512;
    hit  = 1'b0;
`ifdef SRAM_READ_BUFFER_EN
    hit = rd && !wr && buf_valid && (buf_tag == line);
`endif
    if (wr) begin
      ref_w[widx] = d;
    end else begin
      exp_rd = ref_w[widx];
      if (!hit) begin
        buf_valid = 1'b1;
        buf_tag   = line;
      end
    end
    exp_low = wr ? 2*W+1 : (hit ? 1 : W+1);
    we0 = we_cnt;
    rd_en = rd; wr_en = wr; address = a; write_data = d;
    if (from_done) @(negedge clk);
    measure(low);
    check("latency", 64'(low), 64'(exp_low));
    check("read_data", 64'(read_data), 64'(exp_rd));
    check("sram_addr", 64'(SRAM_ADDR), 64'(line));
    check("we_cycles", 64'(we_cnt - we0), 64'(wr ? W : 0));
    if (wr) begin
      check("write_dq", dq_seen, ref_line(line));
      check("sram_line", mem[line[7:0]], ref_line(line));
    end
    in_done = 1'b1;
  endtask

  task automatic op(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                    input bit chain);
    if (in_done && !chain) idle_cycle();
    do_op(rd, wr, a, d, in_done);
  endtask

  task automatic reset_during_write(input logic [31:0] a, input logic [31:0] d);
    int k;
    logic [31:0] off;
    if (in_done) idle_cycle();
    off = a - BASE;
    ref_w[(off >> 2) % 512] = d;
    rd_en = 1'b0; wr_en = 1'b1; address = a; write_data = d;
    k = 0;
    #1;
    while (SRAM_WE_N && k < 50) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("write_reached", 64'(k < 50), 64'd1);
    rst   = 1'b1;
    wr_en = 1'b0;
    @(posedge clk);
    #1;
    check("rst_we_n", 64'(SRAM_WE_N), 64'd1);
    check("rst_ready", 64'(ready), 64'd1);
    @(negedge clk);
    check("rst_read_data", 64'(read_data), 64'd0);
    check("partial_line", mem[off[10:3]], ref_line(off[10:3]));
    rst       = 1'b0;
    exp_rd    = '0;
    buf_valid = 1'b0;
    in_done   = 1'b0;
  endtask

  initial begin
    logic [31:0] a, d;
    int unsigned r;
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
    exp_rd = '0; buf_valid = 1'b0; buf_tag = '0; in_done = 1'b0;

    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      pre_we  = 1'b1;
      pre_idx = 8'(i);
      pre_val = (i == 0) ? 64'h11112222_33334444 : {$urandom, $urandom};
      ref_w[2*i]   = pre_val[31:0];
      ref_w[2*i+1] = pre_val[63:32];
    end
    @(negedge clk);
    pre_we = 1'b0;

    // Reset held two cycles with a load pending.
    rd_en = 1'b1; address = 32'd1028;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset_we_n", 64'(SRAM_WE_N), 64'd1);
    check("reset_read_data", 64'(read_data), 64'd0);
    check("reset_ready", 64'(ready), 64'd0);
    rst = 1'b0;

    op(1'b1, 1'b0, 32'd1028, 32'd0, 1'b0);
    check("tp_load", 64'(read_data), 64'h11112222);
    op(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 1'b0);
    check("tp_store_dq", dq_seen, 64'h11112222_DEADBEEF);

    op(1'b1, 1'b0, 32'd1032, $urandom, 1'b0);
    op(1'b0, 1'b1, 32'd1040, $urandom, 1'b1);

    op(1'b1, 1'b1, 32'd1024, $urandom, 1'b0);

    op(1'b1, 1'b0, 32'd1024, 32'd0, 1'b0);
    op(1'b1, 1'b0, 32'd1024, 32'd0, 1'b0);
    op(1'b0, 1'b1, 32'd1028, 32'hCAFEF00D, 1'b0);
    op(1'b1, 1'b0, 32'd1028, 32'd0, 1'b0);
    check("tp_cafe", 64'(read_data), 64'hCAFEF00D);

    reset_during_write(32'd1048, 32'h0BADF00D);
    op(1'b1, 1'b0, 32'd1048, 32'd0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      r = $urandom % 4;
      a = BASE + ($urandom_range(0, 63) * 4) + ($urandom % 4);
      d = $urandom;
      op(r != 2, r >= 2, a, d, ($urandom % 2) == 1);
    end

    idle_cycle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
